// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: drains a FIFO in BURST_LEN-beat bursts (or a timed-out partial burst) into a registered valid/ready output with last_o on the final beat
module fifo_burst_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT = 16,
  parameter type dtype = logic [DATA_WIDTH-1:0],
  parameter int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                fifo_empty_i,
  input  logic [ADDR_DEPTH:0] fifo_usage_i,
  input  dtype                fifo_data_i,
  output logic                fifo_pop_o,
  output logic                valid_o,
  input  logic                ready_i,
  output dtype                data_o,
  output logic                last_o,
  output logic                busy_o
);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_DEPTH:0] BURST_U = (ADDR_DEPTH + 1)'(BURST_LEN);
  localparam logic [BW-1:0] BURST_B = BW'(BURST_LEN);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);
  localparam logic [WW-1:0] WAIT_FIRE = WW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, BURST, WAIT_LAST} state_t;
  state_t state, state_n;
  logic [BW-1:0] beats_left, beats_left_n;
  logic [WW-1:0] wait_cnt, wait_cnt_n;
  logic valid_n, last_n;
  dtype data_n;
  if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_burst
    $error("fifo_burst_drain: BURST_LEN must be in 1..DEPTH");
  end
  assign fifo_pop_o = state == BURST && !fifo_empty_i && beats_left != '0 && (!valid_o || ready_i) && !flush_i && !rst_i;
  assign busy_o = state != IDLE && !rst_i;
  always_comb begin
    state_n = state;
    beats_left_n = beats_left;
    wait_cnt_n = wait_cnt;
    valid_n = valid_o;
    last_n = last_o;
    data_n = data_o;
    if (state == IDLE) begin
      if (fifo_usage_i >= BURST_U) begin
        state_n = BURST;
        beats_left_n = BURST_B;
        wait_cnt_n = '0;
      end else if (TIMEOUT != 0 && !fifo_empty_i && wait_cnt == WAIT_FIRE) begin
        state_n = BURST;
        beats_left_n = BW'(fifo_usage_i);
        wait_cnt_n = '0;
      end else begin
        wait_cnt_n = fifo_empty_i ? '0 : (wait_cnt == WAIT_MAX ? wait_cnt : wait_cnt + 1'b1);
      end
    end
    if (state == WAIT_LAST && valid_o && ready_i && last_o) state_n = IDLE;
    if (fifo_pop_o) begin
      data_n = fifo_data_i;
      valid_n = 1'b1;
      last_n = beats_left == 1;
      beats_left_n = beats_left - 1'b1;
      state_n = beats_left == 1 ? WAIT_LAST : BURST;
    end else if (valid_o && ready_i) begin
      valid_n = 1'b0;
      last_n = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state <= IDLE;
      beats_left <= '0;
      wait_cnt <= '0;
      valid_o <= 1'b0;
      last_o <= 1'b0;
      data_o <= '0;
    end else begin
      state <= state_n;
      beats_left <= beats_left_n;
      wait_cnt <= wait_cnt_n;
      valid_o <= valid_n;
      last_o <= last_n;
      data_o <= data_n;
    end
  end
endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain: queue-based FIFO and behavioural model checking fifo_burst_drain every cycle
module tb_fifo_burst_drain;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int BL = 4;
  localparam int TO = 16;
  localparam int AW = 3;
  typedef enum int {M_IDLE, M_BURST, M_WAIT} mode_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i, flush_i, fifo_empty_i, ready_i;
  logic [AW:0] fifo_usage_i;
  logic [DW-1:0] fifo_data_i, data_o, data_z;
  logic fifo_pop_o, valid_o, last_o, busy_o;
  logic pop_z, valid_z, last_z, busy_z;
  fifo_burst_drain #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .fifo_empty_i(fifo_empty_i),
    .fifo_usage_i(fifo_usage_i), .fifo_data_i(fifo_data_i), .fifo_pop_o(fifo_pop_o),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o), .busy_o(busy_o)
  );
  fifo_burst_drain #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(0)) dut_z (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .fifo_empty_i(fifo_empty_i),
    .fifo_usage_i(fifo_usage_i), .fifo_data_i(fifo_data_i), .fifo_pop_o(pop_z),
    .valid_o(valid_z), .ready_i(ready_i), .data_o(data_z), .last_o(last_z), .busy_o(busy_z)
  );
  logic [DW-1:0] q[$];
  logic [DW-1:0] hs_d[$];
  bit hs_l[$];
  int errors = 0, checks = 0;
  mode_t mode;
  int rem, idle, pops, first_pop, last_pop, cyc;
  bit ov, ol, rst, flush, ready, chk_z, prev_stall, prev_l;
  logic [DW-1:0] od, prev_d;
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic cycle(input bit push = 1'b0, input logic [DW-1:0] d = '0);
    bit empty, p;
    int usage;
    logic [DW-1:0] head;
    empty = q.size() == 0;
    usage = q.size();
    head = empty ? '0 : q[0];
    rst_i = rst;
    flush_i = flush;
    ready_i = ready;
    fifo_empty_i = empty;
    fifo_usage_i = (AW + 1)'(usage);
    fifo_data_i = head;
    @(negedge clk);
    p = !rst && !flush && mode == M_BURST && !empty && rem != 0 && (!ov || ready);
    chk1("pop", fifo_pop_o, p);
    chk1("busy", busy_o, !rst && mode != M_IDLE);
    chk1("valid", valid_o, ov);
    chkd("data", data_o, od);
    chk1("last", last_o, ol);
    if (chk_z) begin
      chk1("to0_pop", pop_z, 1'b0);
      chk1("to0_valid", valid_z, 1'b0);
      chk1("to0_last", last_z, 1'b0);
      chk1("to0_busy", busy_z, 1'b0);
      chkd("to0_data", data_z, '0);
    end
    if (prev_stall) begin
      chkd("hold_data", data_o, prev_d);
      chk1("hold_last", last_o, prev_l);
    end
    if (valid_o && !ready) chk1("stall_pop", fifo_pop_o, 1'b0);
    prev_stall = valid_o && !ready && !rst && !flush;
    prev_d = data_o;
    prev_l = last_o;
    if (valid_o && ready) begin
      hs_d.push_back(data_o);
      hs_l.push_back(last_o);
    end
    if (fifo_pop_o) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (rst || flush) begin
      mode = M_IDLE; rem = 0; idle = 0; ov = 0; ol = 0; od = '0;
    end else begin
      if (mode == M_IDLE) begin
        if (usage >= BL) begin
          mode = M_BURST; rem = BL; idle = 0;
        end else if (TO != 0 && !empty && idle == TO - 1) begin
          mode = M_BURST; rem = usage; idle = 0;
        end else begin
          idle = empty ? 0 : (idle < TO ? idle + 1 : TO);
        end
      end else if (mode == M_WAIT && ov && ready && ol) begin
        mode = M_IDLE;
      end
      if (p) begin
        od = head; ov = 1; ol = rem == 1;
        if (rem == 1) mode = M_WAIT;
        rem--;
      end else if (ov && ready) begin
        ov = 0; ol = 0;
      end
    end
    if (p) void'(q.pop_front());
    if (push && q.size() < DEPTH) q.push_back(d);
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic clr();
    hs_d.delete();
    hs_l.delete();
    pops = 0;
    first_pop = -1;
    last_pop = -1;
  endtask
  task automatic chk_seq(input string name, input int n, input logic [DW-1:0] e0, e1, e2, e3, input logic [3:0] lm);
    logic [DW-1:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chkd({name, "_count"}, DW'(hs_d.size()), DW'(n));
    for (int i = 0; i < n && i < hs_d.size(); i++) begin
      chkd({name, "_data"}, hs_d[i], e[i]);
      chk1({name, "_last"}, hs_l[i], lm[i]);
    end
  endtask
  initial begin
    int c1;
    rst = 1; flush = 0; ready = 1; chk_z = 0; prev_stall = 0; prev_l = 0; prev_d = '0;
    mode = M_IDLE; rem = 0; idle = 0; ov = 0; ol = 0; od = '0; cyc = 0;
    rst_i = 1; flush_i = 0; ready_i = 1; fifo_empty_i = 1; fifo_usage_i = '0; fifo_data_i = '0;
    clr();
    @(posedge clk);
    #1;
    cycle();
    chk1("reset_valid", valid_o, 1'b0);
    chkd("reset_data", data_o, '0);
    chk1("reset_last", last_o, 1'b0);
    rst = 0;
    cycle();
    cycle(1, 32'h0000_00A1);
    cycle(1, 32'h0000_00B2);
    cycle(1, 32'h0000_00C3);
    cycle(1, 32'h0000_00D4);
    for (int i = 0; i < 10; i++) cycle();
    chk_seq("s1", 4, 32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3, 32'h0000_00D4, 4'b1000);
    chkd("s1_pops", DW'(pops), 32'd4);
    chkd("s1_span", DW'(last_pop - first_pop), 32'd3);
    chk1("s1_busy_end", busy_o, 1'b0);
    rst = 1;
    cycle();
    rst = 0;
    chk_z = 1;
    clr();
    cycle(1, 32'h0000_00E5);
    c1 = cyc;
    cycle(1, 32'h0000_00F6);
    for (int i = 0; i < 30; i++) cycle();
    chkd("s2_first_pop", DW'(first_pop - c1), 32'd16);
    chkd("s2_pops", DW'(pops), 32'd2);
    chk_seq("s2", 2, 32'h0000_00E5, 32'h0000_00F6, '0, '0, 4'b0010);
    chk_z = 0;
    clr();
    cycle(1, 32'h1111_0001);
    cycle(1, 32'h1111_0002);
    cycle(1, 32'h1111_0003);
    cycle(1, 32'h1111_0004);
    for (int i = 0; i < 24; i++) begin
      ready = (i % 4 == 0) || (i % 4 == 3);
      cycle();
    end
    ready = 1;
    for (int i = 0; i < 4; i++) cycle();
    chk_seq("s3", 4, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0004, 4'b1000);
    chkd("s3_pops", DW'(pops), 32'd4);
    clr();
    cycle(1, 32'h2222_0001);
    c1 = cyc;
    for (int i = 0; i < 12; i++) cycle();
    cycle(1, 32'h2222_0002);
    cycle(1, 32'h2222_0003);
    cycle(1, 32'h2222_0004);
    for (int i = 0; i < 15; i++) cycle();
    chkd("s4_first_pop", DW'(first_pop - c1), 32'd16);
    chk_seq("s4", 4, 32'h2222_0001, 32'h2222_0002, 32'h2222_0003, 32'h2222_0004, 4'b1000);
    clr();
    cycle(1, 32'h3333_0001);
    cycle(1, 32'h3333_0002);
    cycle(1, 32'h3333_0003);
    cycle(1, 32'h3333_0004);
    for (int i = 0; i < 20 && pops < 2; i++) cycle();
    chkd("s5_setup_pops", DW'(pops), 32'd2);
    chk1("s5_setup_valid", valid_o, 1'b1);
    flush = 1;
    ready = 0;
    cycle();
    flush = 0;
    ready = 1;
    chk1("s5_flush_valid", valid_o, 1'b0);
    chk1("s5_flush_busy", busy_o, 1'b0);
    for (int i = 0; i < 40; i++) cycle();
    chk_seq("s5", 3, 32'h3333_0001, 32'h3333_0003, 32'h3333_0004, '0, 4'b0100);
    clr();
    cycle(1, 32'h4444_0001);
    cycle(1, 32'h4444_0002);
    cycle(1, 32'h4444_0003);
    cycle(1, 32'h4444_0004);
    for (int i = 0; i < 20 && pops < 2; i++) cycle();
    chkd("s6_setup_pops", DW'(pops), 32'd2);
    rst = 1;
    cycle();
    rst = 0;
    chk1("s6_rst_valid", valid_o, 1'b0);
    chkd("s6_rst_data", data_o, '0);
    chk1("s6_rst_last", last_o, 1'b0);
    chk1("s6_rst_busy", busy_o, 1'b0);
    clr();
    cycle(1, 32'h4444_0005);
    cycle(1, 32'h4444_0006);
    for (int i = 0; i < 12; i++) cycle();
    chk_seq("s6", 4, 32'h4444_0003, 32'h4444_0004, 32'h4444_0005, 32'h4444_0006, 4'b1000);
    for (int i = 0; i < 3000; i++) begin
      ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 99) == 0;
      rst = $urandom_range(0, 299) == 0;
      cycle($urandom_range(0, 9) < 4, $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
